// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Imported by the loader top and its word packer.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } boot_state_t;

   localparam int         BYTES_PER_WORD = 4;
   localparam logic [7:0] CKSUM_INIT     = 8'h00;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Packs four LSB-first bytes into one 32-bit word.
// Emits a registered one-cycle valid when the fourth byte lands.
module boot_word_packer
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        byte_vld_i,
   input  logic [7:0]  byte_i,
   output logic        last_o,
   output logic        word_vld_o,
   output logic [31:0] word_o
);

   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  lane_q;
   logic [23:0] shr_q;
   logic        vld_q;
   logic [31:0] word_q;

   assign last_o     = (lane_q == LAST_LANE);
   assign word_vld_o = vld_q;
   assign word_o     = word_q;

   // Shift bytes in from the top; the word register holds between pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane_q <= '0;
         shr_q  <= '0;
         vld_q  <= 1'b0;
         word_q <= '0;
      end else begin
         vld_q <= 1'b0;
         if (clr_i) begin
            lane_q <= '0;
         end else if (byte_vld_i) begin
            lane_q <= lane_q + 2'd1;
            shr_q  <= {byte_i, shr_q[23:8]};
            if (last_o) begin
               vld_q  <= 1'b1;
               word_q <= {byte_i, shr_q};
            end
         end
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: length-prefixed, XOR-checked byte stream into imem.
// Holds the core in reset until the image has loaded and verified.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          boot_req,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          core_rst_n,
   output logic          busy,
   output logic          done,
   output logic          error
);

   boot_state_t   state_q, state_d;
   logic [15:0]   len_q;
   logic [AW:0]   widx_q;
   logic [7:0]    cks_q;
   logic [AW-1:0] addr_q;
   logic          xfer;
   logic          data_xfer;
   logic          last_byte;
   logic          last_word;
   logic          enter_len0;
   logic [15:0]   len_full;

   assign in_ready = (state_q == ST_LEN0) | (state_q == ST_LEN1) |
                     (state_q == ST_DATA) | (state_q == ST_CHECK);
   assign busy       = in_ready;
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERROR);
   assign core_rst_n = done;
   assign imem_addr  = addr_q;

   assign xfer      = in_valid & in_ready;
   assign data_xfer = xfer & (state_q == ST_DATA);
   assign len_full  = {in_data, len_q[7:0]};
   assign last_word = ((16'(widx_q) + 16'd1) == len_q);

   boot_word_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (enter_len0),
      .byte_vld_i (data_xfer),
      .byte_i     (in_data),
      .last_o     (last_byte),
      .word_vld_o (imem_we),
      .word_o     (imem_wdata)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; boot_req only counts outside a load.
   always_comb begin
      state_d    = state_q;
      enter_len0 = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (boot_req) begin
               state_d    = ST_LEN0;
               enter_len0 = 1'b1;
            end
         end
         ST_LEN0: if (xfer) state_d = ST_LEN1;
         ST_LEN1: begin
            if (xfer) begin
               if (len_full > 16'(DEPTH))  state_d = ST_ERROR;
               else if (len_full == 16'd0) state_d = ST_CHECK;
               else                        state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (data_xfer && last_byte && last_word) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (xfer) state_d = (in_data == cks_q) ? ST_DONE : ST_ERROR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Length capture, running XOR and word index / write address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q  <= '0;
         widx_q <= '0;
         cks_q  <= CKSUM_INIT;
         addr_q <= '0;
      end else begin
         if (enter_len0) begin
            widx_q <= '0;
            cks_q  <= CKSUM_INIT;
         end
         if (xfer && state_q == ST_LEN0) len_q[7:0]  <= in_data;
         if (xfer && state_q == ST_LEN1) len_q[15:8] <= in_data;
         if (data_xfer) begin
            cks_q <= cks_q ^ in_data;
            if (last_byte) begin
               addr_q <= widx_q[AW-1:0];
               widx_q <= widx_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader.
// Expected writes are queued by the driver and popped by a monitor.
module tb_imem_boot_loader;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          boot_req = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst_n;
   logic          busy;
   logic          done;
   logic          error;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [31:0] img_w[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_wr = 0;
   int          gap_pct = 0;

   imem_boot_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .boot_req   (boot_req),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every write must match the next queued expectation.
   always @(negedge clk) begin
      if (imem_we) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %h, expected none",
                     imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(imem_addr), mon_e.addr);
            check("wr_data", imem_wdata, mon_e.data);
         end
      end
   end

   task automatic chk_reset_vals();
      check("rst_in_ready", in_ready, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_imem_addr", 32'(imem_addr), 0);
      check("rst_imem_wdata", imem_wdata, 0);
      check("rst_core_rst_n", core_rst_n, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte transfers.
   task automatic send_byte(input logic [7:0] b);
      int   t;
      logic r;
      t = 0;
      while ($urandom_range(99) < gap_pct) begin
         r        = in_ready;
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         #1;
         check("ready_indep_of_valid", in_ready, r);
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL byte_timeout: got in_ready 0, expected 1");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_boot();
      boot_req = 1'b1;
      @(posedge clk);
      #1;
      boot_req = 1'b0;
      check("boot_in_ready", in_ready, 1);
      check("boot_busy", busy, 1);
      check("boot_core_rst_n", core_rst_n, 0);
   endtask

   // Reference model: builds the stream from img_w and queues expectations.
   task automatic run_image(input int n, input bit bad_ck);
      logic [7:0]  ck;
      logic [31:0] w;
      ck = 8'h00;
      do_boot();
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      if (n > DEPTH) begin
         check("ovf_error", error, 1);
         check("ovf_busy", busy, 0);
         check("ovf_core_rst_n", core_rst_n, 0);
         repeat (4) @(posedge clk);
         #1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         w = img_w[k];
         exp_q.push_back('{k, w});
         for (int b = 0; b < 4; b++) begin
            ck = ck ^ w[8*b +: 8];
            send_byte(w[8*b +: 8]);
         end
      end
      send_byte(bad_ck ? (ck ^ 8'h01) : ck);
      check("writes_drained", exp_q.size(), 0);
      check("end_done", done, !bad_ck);
      check("end_error", error, bad_ck);
      check("end_core_rst_n", core_rst_n, !bad_ck);
      check("end_busy", busy, 0);
   endtask

   initial begin
      int wr0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      img_w = '{32'h00500093, 32'h00A00113};
      run_image(2, 1'b0);
      run_image(2, 1'b1);
      run_image(2, 1'b0);

      run_image(16'h0401, 1'b0);
      run_image(0, 1'b0);

      gap_pct = 30;
      img_w.delete();
      for (int i = 0; i < DEPTH; i++) img_w.push_back($urandom);
      wr0 = n_wr;
      run_image(DEPTH, 1'b0);
      check("full_write_count", n_wr - wr0, DEPTH);

      gap_pct = 0;
      img_w.delete();
      img_w.push_back(32'h11223344);
      do_boot();
      send_byte(8'h03);
      send_byte(8'h00);
      exp_q.push_back('{0, 32'h11223344});
      send_byte(8'h44);
      send_byte(8'h33);
      send_byte(8'h22);
      send_byte(8'h11);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (2) @(posedge clk);
      #1;
      check("midreset_pre_drained", exp_q.size(), 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_vals();
      rst_n = 1'b1;
      img_w.delete();
      img_w.push_back(32'hDEADBEEF);
      run_image(1, 1'b0);

      gap_pct = 20;
      for (int r = 0; r < 6; r++) begin
         img_w.delete();
         for (int i = 0; i < 6; i++) img_w.push_back($urandom);
         run_image(int'($urandom_range(1, 6)), bit'($urandom_range(1)));
      end

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
